// File: rtl/cic_nr16.sv
// Recursive CIC decimator: 1-bit PDM stream in, unsigned PCM sample out once per clkdiv period.
// Optional CICNR16_VALID_EN adds a y_valid strobe coincident with each y_out update.
module cic_nr16 #(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned RATE_LOG2 = 5,
  parameter int unsigned OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkdiv,
  input  logic             x_in,
`ifdef CICNR16_VALID_EN
  output logic             y_valid,
`endif
  output logic [OUT_W-1:0] y_out
);

  localparam int unsigned W = STAGES * RATE_LOG2 + 1;

  logic [W-1:0] integ_q [STAGES];
  logic [W-1:0] integ_d [STAGES];
  logic [W-1:0] dly_q   [STAGES];
  logic [W-1:0] comb_tap[STAGES];
  logic [W-1:0] comb_out;
  logic [W-1:0] acc;
  logic [OUT_W-1:0] y_q;
  logic         clkdiv_q;
  logic         strobe;

  assign strobe = clkdiv & ~clkdiv_q;

  always_comb begin
    integ_d[0] = integ_q[0] + {{(W-1){1'b0}}, x_in};
    for (int k = 1; k < STAGES; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // Comb chain is combinational; each tap is what its delay register captures on a strobe.
  always_comb begin
    acc = integ_q[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      comb_tap[k] = acc;
      acc         = acc - dly_q[k];
    end
    comb_out = acc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      clkdiv_q <= 1'b0;
      y_q      <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
      end
      clkdiv_q <= clkdiv;
      if (strobe) begin
        for (int k = 0; k < STAGES; k++) begin
          dly_q[k] <= comb_tap[k];
        end
        y_q <= comb_out;
      end
    end
  end

  assign y_out = y_q;

`ifdef CICNR16_VALID_EN
  logic valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= strobe;
    end
  end

  assign y_valid = valid_q;
`endif

endmodule

// File: tb/tb_cic_nr16.sv
// Self-checking bench for cic_nr16: output compared every clk against a convolution model
// (PDM history dotted with the CIC impulse response, boxcar-32 convolved three times).
module tb_cic_nr16;

  logic        clk;
  logic        rst;
  logic        clkdiv;
  logic        x_in;
  logic [15:0] y_out;
`ifdef CICNR16_VALID_EN
  logic        y_valid;
`endif

  cic_nr16 #(
    .STAGES   (3),
    .RATE_LOG2(5),
    .OUT_W    (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clkdiv (clkdiv),
    .x_in   (x_in),
`ifdef CICNR16_VALID_EN
    .y_valid(y_valid),
`endif
    .y_out  (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int h1[32];
  int h2[63];
  int h3[94];
  bit xh[0:16383];
  int cnt = 0;
  int ph  = 0;
  logic [15:0] y_exp = '0;
  logic        v_exp = 1'b0;

  // Output at strobe edge e is sum over m of h3[m] * x(e-3-m), modulo 2^16.
  function automatic logic [15:0] model_y(input int e);
    int sum;
    sum = 0;
    for (int m = 0; m < 94; m++) begin
      if (e - 3 - m >= 1) sum += h3[m] * int'(xh[e-3-m]);
    end
    return sum[15:0];
  endfunction

  task automatic tick(input logic xb, input string tag);
    logic strobe_m;
    logic in_reset;
    @(negedge clk);
    x_in     = xb;
    clkdiv   = ((ph % 32) >= 16);
    in_reset = !rst;
    strobe_m = rst && ((ph % 32) == 16);
    ph++;
    @(posedge clk);
    #1;
    if (in_reset) begin
      cnt   = 0;
      y_exp = '0;
      v_exp = 1'b0;
    end else begin
      cnt++;
      xh[cnt] = xb;
      v_exp   = strobe_m;
      if (strobe_m) y_exp = model_y(cnt);
    end
    checks++;
    assert (y_out === y_exp) else begin
      errors++;
      $error("FAIL %s y_out got %0d exp %0d (edge %0d)", tag, y_out, y_exp, cnt);
    end
`ifdef CICNR16_VALID_EN
    checks++;
    assert (y_valid === v_exp) else begin
      errors++;
      $error("FAIL %s_valid y_valid got %0b exp %0b (edge %0d)", tag, y_valid, v_exp, cnt);
    end
`endif
  endtask

  // Reset lands in the low half of clkdiv so the first post-release strobe is a genuine edge.
  task automatic align_reset(input logic xb);
    while ((ph % 32) != 2) tick(xb, "align");
    rst = 1'b0;
    tick(xb, "reset");
    rst = 1'b1;
  endtask

  task automatic check_const(input logic [15:0] exp, input string tag);
    checks++;
    assert (y_out === exp) else begin
      errors++;
      $error("FAIL %s y_out got %0d exp %0d", tag, y_out, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) h1[i] = 1;
    for (int i = 0; i < 63; i++) h2[i] = 0;
    for (int i = 0; i < 94; i++) h3[i] = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) h2[i+j] += h1[i] * h1[j];
    for (int i = 0; i < 63; i++)
      for (int j = 0; j < 32; j++) h3[i+j] += h2[i] * h1[j];

    rst    = 1'b0;
    x_in   = 1'b0;
    clkdiv = 1'b0;

    for (int i = 0; i < 3; i++) tick(1'b0, "cold_reset");
    check_const(16'd0, "reset_zero");
    rst = 1'b1;

    for (int i = 0; i < 200; i++) tick(1'b0, "zeros");
    check_const(16'd0, "zeros_const");

    align_reset(1'b0);
    for (int i = 0; i < 5 * 32; i++) tick(1'b1, "ones_settle");
    check_const(16'd32768, "ones_const");

    for (int i = 0; i < 5100; i++) tick(1'b1, "ones_wrap");
    check_const(16'd32768, "ones_wrap_const");

    for (int i = 0; i < 8 * 32; i++) tick(1'(i % 2 == 0), "alt10");
    check_const(16'd16384, "alt10_const");

    for (int i = 0; i < 8 * 32; i++) tick(1'(i % 4 == 0), "p1000");
    check_const(16'd8192, "p1000_const");

    for (int i = 0; i < 400; i++) tick(1'($urandom_range(1, 0)), "random");

    align_reset(1'($urandom_range(1, 0)));
    check_const(16'd0, "mid_reset_zero");
    for (int i = 0; i < 3 * 32; i++) tick(1'($urandom_range(3, 0) != 0), "post_reset_rand");

    align_reset(1'b1);
    for (int i = 0; i < 5 * 32; i++) tick(1'b1, "reconverge");
    check_const(16'd32768, "reconverge_const");

`ifdef CICNR16_VALID_EN
    begin
      int vcount;
      int last;
      int gap_err;
      vcount  = 0;
      last    = -1;
      gap_err = 0;
      for (int i = 0; i < 320; i++) begin
        tick(1'b1, "valid_window");
        if (y_valid === 1'b1) begin
          if (last >= 0 && cnt - last != 32) gap_err++;
          last = cnt;
          vcount++;
        end
      end
      checks++;
      assert (vcount == 10) else begin
        errors++;
        $error("FAIL valid_count got %0d exp 10", vcount);
      end
      checks++;
      assert (gap_err == 0) else begin
        errors++;
        $error("FAIL valid_spacing bad gaps %0d exp 0", gap_err);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
